// File: rtl/float_mult_pipe.sv
// -----------------------------------------------------------------------------
// float_mult_pipe
//   Three-stage pipelined multiplier for a small sign/exponent/mantissa format
//   with a hidden leading one, no subnormals and no Inf/NaN encodings.
//   Out-of-range products saturate (ovf) or flush to signed zero (unf).
//
//   Stage 1: unpack, sign xor, exponent sum, mantissa product
//   Stage 2: normalise the product so the leading one sits in a fixed place
//   Stage 3: round to nearest even, range check, pack (drives the outputs)
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   in_valid   operand pair a/b presented
//   in_ready   block accepts the pair this cycle
//   a, b       operands {sign, exp[EXP_W], man[MAN_W]}
//   out_valid  result/ovf/unf hold a valid product
//   out_ready  downstream consumes the result this cycle
//   result     packed product
//   ovf        product saturated to the largest magnitude
//   unf        product flushed to zero
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. in_ready is driven from the output side only (never from
// in_valid): the whole pipe advances together when the output register is
// empty or being consumed. While out_valid=1 and out_ready=0 every stage,
// including the outputs, holds its contents.
// -----------------------------------------------------------------------------
module float_mult_pipe #(
  parameter int EXP_W = 4,
  parameter int MAN_W = 3,
  parameter int BIAS  = 2**(EXP_W-1)-1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [EXP_W+MAN_W:0] a,
  input  logic [EXP_W+MAN_W:0] b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [EXP_W+MAN_W:0] result,
  output logic                 ovf,
  output logic                 unf
);

  localparam int W  = 1 + EXP_W + MAN_W;
  // Signed exponent width: wide enough for the full sum, the bias
  // subtraction and two increments without wrapping before the range check.
  localparam int EW = EXP_W + 2;
  localparam int PW = 2*MAN_W + 2;

  localparam logic signed [EW-1:0] EXP_ONE = EW'(1);
  localparam logic signed [EW-1:0] EXP_MAX = EW'(2**EXP_W - 1);

  logic w_advance;

  // Stage 1 registers
  logic                 r1_valid;
  logic                 r1_sign;
  logic                 r1_zero;
  logic signed [EW-1:0] r1_exp;
  logic [PW-1:0]        r1_prod;

  // Stage 2 registers: fraction bits below the leading one, left aligned
  logic                 r2_valid;
  logic                 r2_sign;
  logic                 r2_zero;
  logic signed [EW-1:0] r2_exp;
  logic [PW-2:0]        r2_frac;

  // Stage 3 registers (outputs)
  logic                 r3_valid;
  logic [W-1:0]         r3_result;
  logic                 r3_ovf;
  logic                 r3_unf;

  // Stage 1 combinational
  logic                 w1_sign;
  logic                 w1_zero;
  logic signed [EW-1:0] w1_exp;
  logic [PW-1:0]        w1_prod;

  // Stage 2 combinational
  logic signed [EW-1:0] w2_exp;
  logic [PW-2:0]        w2_frac;

  // Stage 3 combinational
  logic [MAN_W-1:0]     w3_kept;
  logic                 w3_guard;
  logic                 w3_sticky;
  logic                 w3_inc;
  logic [MAN_W:0]       w3_rnd;
  logic signed [EW-1:0] w3_exp;
  logic [W-1:0]         w3_result;
  logic                 w3_ovf;
  logic                 w3_unf;

  assign w_advance = !r3_valid || out_ready;
  assign in_ready  = w_advance;

  assign out_valid = r3_valid;
  assign result    = r3_result;
  assign ovf       = r3_ovf;
  assign unf       = r3_unf;

  // ---------------------------------------------------------------- stage 1
  assign w1_sign = a[W-1] ^ b[W-1];
  assign w1_zero = (a[W-2 -: EXP_W] == '0) || (b[W-2 -: EXP_W] == '0);
  assign w1_exp  = {2'b00, a[W-2 -: EXP_W]} + {2'b00, b[W-2 -: EXP_W]}
                 - EW'(BIAS);
  assign w1_prod = PW'({1'b1, a[MAN_W-1:0]}) * PW'({1'b1, b[MAN_W-1:0]});

  // ---------------------------------------------------------------- stage 2
  // The product of two values in [1,2) lies in [1,4): either the top bit or
  // the one below it is the leading one. Dropping it leaves the fraction.
  assign w2_exp  = r1_prod[PW-1] ? r1_exp + EXP_ONE : r1_exp;
  assign w2_frac = r1_prod[PW-1] ? r1_prod[PW-2:0]
                                 : {r1_prod[PW-3:0], 1'b0};

  // ---------------------------------------------------------------- stage 3
  assign w3_kept   = r2_frac[PW-2 -: MAN_W];
  assign w3_guard  = r2_frac[MAN_W];
  assign w3_sticky = |r2_frac[MAN_W-1:0];
  assign w3_inc    = w3_guard && (w3_sticky || w3_kept[0]);
  assign w3_rnd    = {1'b0, w3_kept} + {{MAN_W{1'b0}}, w3_inc};
  // A carry out of the mantissa leaves its low bits all zero already, so
  // only the exponent needs bumping.
  assign w3_exp    = w3_rnd[MAN_W] ? r2_exp + EXP_ONE : r2_exp;

  always_comb begin
    w3_result = '0;
    w3_ovf    = 1'b0;
    w3_unf    = 1'b0;
    if (r2_zero) begin
      w3_result = {r2_sign, {(W-1){1'b0}}};
    end else if (w3_exp > EXP_MAX) begin
      w3_result = {r2_sign, {(W-1){1'b1}}};
      w3_ovf    = 1'b1;
    end else if (w3_exp < EXP_ONE) begin
      w3_result = {r2_sign, {(W-1){1'b0}}};
      w3_unf    = 1'b1;
    end else begin
      w3_result = {r2_sign, w3_exp[EXP_W-1:0], w3_rnd[MAN_W-1:0]};
    end
  end

  // ---------------------------------------------------------------- registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r1_valid  <= 1'b0;
      r1_sign   <= 1'b0;
      r1_zero   <= 1'b0;
      r1_exp    <= '0;
      r1_prod   <= '0;
      r2_valid  <= 1'b0;
      r2_sign   <= 1'b0;
      r2_zero   <= 1'b0;
      r2_exp    <= '0;
      r2_frac   <= '0;
      r3_valid  <= 1'b0;
      r3_result <= '0;
      r3_ovf    <= 1'b0;
      r3_unf    <= 1'b0;
    end else if (w_advance) begin
      r1_valid  <= in_valid;
      r1_sign   <= w1_sign;
      r1_zero   <= w1_zero;
      r1_exp    <= w1_exp;
      r1_prod   <= w1_prod;
      r2_valid  <= r1_valid;
      r2_sign   <= r1_sign;
      r2_zero   <= r1_zero;
      r2_exp    <= w2_exp;
      r2_frac   <= w2_frac;
      r3_valid  <= r2_valid;
      r3_result <= w3_result;
      r3_ovf    <= w3_ovf;
      r3_unf    <= w3_unf;
    end
  end

endmodule

// File: doc/float_mult_pipe.md
FLOAT_MULT_PIPE -- requirements
Module: float_mult_pipe

Interface
REQ-001 The block SHALL take parameter EXP_W, default 4, exponent field width.
REQ-002 The block SHALL take parameter MAN_W, default 3, stored mantissa field width, with no hidden bit stored.
REQ-003 The block SHALL take parameter BIAS, default 2**(EXP_W-1)-1 (7 at default), exponent bias; W = 1+EXP_W+MAN_W (8 at default).
REQ-004 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port rst, input, 1, reset; asynchronous, active-high.
REQ-006 The block SHALL have port in_valid, input, 1, operand pair a/b presented.
REQ-007 The block SHALL have port in_ready, output, 1, block accepts the operand pair this cycle.
REQ-008 The block SHALL have ports a and b, input, W each, operands {sign, exp, man}.
REQ-009 The block SHALL have port out_valid, output, 1, result/flags hold a valid product.
REQ-010 The block SHALL have port out_ready, input, 1, downstream consumes the result.
REQ-011 The block SHALL have port result, output, W, packed product.
REQ-012 The block SHALL have port ovf, output, 1, product saturated.
REQ-013 The block SHALL have port unf, output, 1, product flushed to zero.

Function
REQ-014 The block SHALL be a 3-stage pipeline; each stage holds a valid bit:
- S1: unpack, sign xor, exponent sum, mantissa product.
- S2: normalise.
- S3: round, range check, pack; S3 registers drive result/ovf/unf/out_valid.
REQ-015 The block SHALL compute advance = !out_valid | out_ready, drive in_ready = advance, and move all stages together only when advance=1.
REQ-016 A pair SHALL transfer when in_valid & in_ready, a result when out_valid & out_ready, with latency 3 cycles from input transfer to out_valid under continuous out_ready=1.
REQ-017 Under stall (out_valid=1, out_ready=0), result/ovf/unf/out_valid and all stage contents SHALL hold unchanged.
REQ-018 Results SHALL emerge in acceptance order; none dropped or duplicated; throughput 1/cycle with out_ready=1; bubbles propagate as out_valid=0.
REQ-019 Sign SHALL equal sign_a xor sign_b in all cases, including zero results.
REQ-020 An operand with exp field 0 SHALL be treated as zero (no subnormals); the product SHALL be signed zero with ovf=0, unf=0.
REQ-021 Exp field all-ones SHALL be an ordinary finite exponent (no Inf/NaN encodings).
REQ-022 Mantissa product SHALL be {1,man_a}*{1,man_b}, 2*MAN_W+2 bits; if its MSB is 1, shift right 1 and increment the exponent.
REQ-023 Exponent SHALL be computed as exp_a+exp_b-BIAS in a signed EXP_W+2-bit width, with no truncation before the range check.
REQ-024 Rounding SHALL be round-to-nearest-even: guard = bit below kept LSB, sticky = OR of remaining bits; increment if guard & (sticky | LSB).
REQ-025 A rounding carry-out SHALL set mantissa 0 and increment the exponent.
REQ-026 Post-round exponent > 2**EXP_W-1 SHALL give result {sign, all-ones exp, all-ones man} with ovf=1.
REQ-027 Post-round exponent < 1 SHALL give result {sign, zeros} with unf=1.
REQ-028 ovf and unf SHALL be mutually exclusive and valid only while out_valid=1.

Reset
REQ-029 rst=1 SHALL immediately clear all stage valid bits and set out_valid=0, result=0, ovf=0, unf=0.
REQ-030 in_ready SHALL read 1 during and after reset, since out_valid=0.
REQ-031 In-flight operations SHALL be discarded on reset, with no result emitted after release.

Verification
REQ-032 Basic: default params, out_ready=1, a=0x38, b=0x38 -> 0x38 three cycles later; 0x3C*0x3C -> 0x41; flags 0.
REQ-033 Rounding tie: 0x3C*0x39 (1.5*1.125) -> 0x3E; 0x39*0x39 -> 0x3A.
REQ-034 Range: 0x70*0x70 -> 0x7F, ovf=1; 0x08*0x08 -> 0x00, unf=1; 0x80*0x38 -> 0x80, flags 0; 0x00*0x7F -> 0x00.
REQ-035 Backpressure: out_ready=0, in_valid=1 with distinct pairs -> exactly 3 accepted, then in_ready=0 and outputs stable; out_ready=1 -> the 3 results in order, then streaming resumes at 1/cycle.
REQ-036 Reset mid-flight: 2 pairs accepted, assert rst asynchronously between edges -> out_valid=0 at once; after release no stale result appears.
REQ-037 Parametric: EXP_W=5, MAN_W=10, BIAS=15; 0x3C00*0x4000 (1.0*2.0) -> 0x4000; random-vs-reference model, 10k vectors, zero mismatches.
